// File: rtl/bcd_press_counter.sv
// bcd_press_counter
//   Four-digit BCD up/down event counter driven by a debounced, active-low
//   pushbutton. Each accepted press adds or subtracts one in BCD. The digit
//   outputs feed seven-segment decoders directly.
//
// Ports
//   CLOCK_50 : system clock, all logic on the rising edge
//   reset_n  : asynchronous active-low reset
//   btn_n    : raw bouncy pushbutton, active-low, asynchronous to CLOCK_50
//   up       : direction (1 = increment, 0 = decrement), used only on the accepting edge
//   clear    : synchronous clear of the count; takes priority over a press
//   digits   : {d3,d2,d1,d0}, each digit 0..9
//   step     : one-cycle pulse in the cycle digits take a press result
//   wrap     : one-cycle pulse with step on 9999->0000 or 0000->9999
module bcd_press_counter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        btn_n,
  input  logic        up,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        step,
  output logic        wrap
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Count value at which the input has been stable for DEBOUNCE_CYCLES samples.
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_reg;
  logic        s;
  logic [1:0]  state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic        accept;

  logic [15:0] digits_reg, digits_next;
  logic        step_reg;
  logic        wrap_reg, wrap_next;

  // Two-flop synchronizer; resets to "released".
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], btn_n};
  end

  assign s = sync_reg[1];

  // Debounce FSM. A press is accepted once, on the PRESS_WAIT -> PRESSED
  // transition; holding the button just parks the FSM in PRESSED.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!s) begin
          state_next = PRESS_WAIT;
          cnt_next   = 20'd1;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end
      PRESSED: begin
        if (s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = 20'd1;
        end
      end
      default: begin // RELEASE_WAIT
        if (!s) begin
          state_next = PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 20'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // BCD ripple increment / decrement. carry[gi] / borrow[gi] is the unit
  // entering digit gi; the chain out of digit 3 is the wrap indication.
  logic [4:0]  carry;
  logic [4:0]  borrow;
  logic [15:0] inc_digits;
  logic [15:0] dec_digits;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur = digits_reg[gi*4 +: 4];

      assign carry[gi+1]  = carry[gi]  && (cur == 4'd9);
      assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);

      assign inc_digits[gi*4 +: 4] = !carry[gi]   ? cur :
                                     (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      assign dec_digits[gi*4 +: 4] = !borrow[gi]  ? cur :
                                     (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    end
  endgenerate

  assign digits_next = up ? inc_digits : dec_digits;
  assign wrap_next   = up ? carry[4]   : borrow[4];

  // Clear outranks a simultaneous press; the press is simply dropped.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      digits_reg <= 16'h0000;
      step_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else if (clear) begin
      digits_reg <= 16'h0000;
      step_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else if (accept) begin
      digits_reg <= digits_next;
      step_reg   <= 1'b1;
      wrap_reg   <= wrap_next;
    end else begin
      step_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end
  end

  assign digits = digits_reg;
  assign step   = step_reg;
  assign wrap   = wrap_reg;

endmodule

// File: tb/tb_bcd_press_counter.sv
module tb_bcd_press_counter;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_n;
  logic        up;
  logic        clear;
  logic [15:0] digits;
  logic        step;
  logic        wrap;

  bcd_press_counter #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .btn_n    (btn_n),
    .up       (up),
    .clear    (clear),
    .digits   (digits),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        w;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   count  = 0;   // reference count, plain integer 0..9999
  int   nstep  = 0;

  function automatic logic [15:0] to_bcd(input int c);
    to_bcd = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every step pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (step === 1'b1) begin
        nstep++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: got digits=%h wrap=%b expected no step", digits, wrap);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (digits !== e.d || wrap !== e.w) begin
            errors++;
            $display("FAIL step_result: got digits=%h wrap=%b expected digits=%h wrap=%b",
                     digits, wrap, e.d, e.w);
          end else begin
            $display("step digits=%h wrap=%b", digits, wrap);
          end
        end
      end else if (wrap === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL wrap_without_step: got wrap=1 expected 0");
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Record the press outcome from the reference model.
  task automatic expect_press(input logic dir);
    exp_t e;
    e.w   = dir ? (count == 9999) : (count == 0);
    count = dir ? (count + 1) % 10000 : (count + 9999) % 10000;
    e.d   = to_bcd(count);
    exp_q.push_back(e);
  endtask

  // One full press/release. Bounces are 2-cycle glitches, too short to qualify.
  task automatic press(input logic dir, input bit bouncy, input int hold, input bit chk);
    up = dir;
    expect_press(dir);
    if (bouncy) begin
      for (int i = 0; i < 5; i++) begin
        btn_n = 1'b0; cyc(2);
        btn_n = 1'b1; cyc(2);
      end
    end
    btn_n = 1'b0;
    cyc(hold);
    if (bouncy) begin
      for (int i = 0; i < 3; i++) begin
        btn_n = 1'b1; cyc(2);
        btn_n = 1'b0; cyc(2);
      end
    end
    btn_n = 1'b1;
    cyc(10);
    if (chk) check("digits_after_press", 32'(digits), 32'(to_bcd(count)));
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    btn_n   = 1'b1;
    up      = 1'b1;
    clear   = 1'b0;
    cyc(3);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_step",   32'(step),   32'h0);
    check("reset_wrap",   32'(wrap),   32'h0);
    reset_n = 1'b1;
    cyc(2);

    // Climb to 0999 with clean presses; carries exercised along the way.
    for (int i = 0; i < 999; i++) press(1'b1, 1'b0, 8, (i % 100) == 99);
    press(1'b1, 1'b0, 8, 1'b1);            // 0999 -> 1000, no wrap
    press(1'b0, 1'b0, 8, 1'b1);            // 1000 -> 0999 borrow

    // Asynchronous reset in the middle of a qualification.
    up    = 1'b1;
    btn_n = 1'b0;
    cyc(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_digits", 32'(digits), 32'h0);
    check("async_reset_step",   32'(step),   32'h0);
    check("async_reset_wrap",   32'(wrap),   32'h0);
    count = 0;
    cyc(2);
    reset_n = 1'b1;
    // Button still low: full qualification again, step 5 edges after first capture.
    expect_press(1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("press_latency_edges", 32'(lat), 32'd6);
    @(negedge clk);
    btn_n = 1'b1;
    cyc(10);
    check("digits_after_reset_press", 32'(digits), 32'h0001);

    // Synchronous clear, then wraps in both directions.
    clear = 1'b1; cyc(1); clear = 1'b0;
    count = 0;
    check("clear_digits", 32'(digits), 32'h0);
    press(1'b0, 1'b0, 8, 1'b1);            // 0000 -> 9999 wrap
    press(1'b1, 1'b0, 8, 1'b1);            // 9999 -> 0000 wrap

    // Bouncy press and release: exactly one step.
    press(1'b1, 1'b1, 8, 1'b1);

    // Long hold with up toggled after acceptance: one step only.
    up    = 1'b1;
    expect_press(1'b1);
    btn_n = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i > 20 && (i % 7) == 0) up = ~up;
      cyc(1);
    end
    btn_n = 1'b1;
    cyc(10);
    check("digits_after_hold", 32'(digits), 32'(to_bcd(count)));

    // Bring count to 0042, then clear on the exact accepting edge.
    while (count != 42) press(1'b1, 1'b0, 8, 1'b0);
    check("digits_before_collision", 32'(digits), 32'h0042);
    up    = 1'b1;
    btn_n = 1'b0;
    repeat (5) @(posedge clk);             // edge N+4
    #1 clear = 1'b1;
    @(posedge clk);                        // accepting edge N+5
    #1 clear = 1'b0;
    count = 0;
    check("collision_digits", 32'(digits), 32'h0);
    check("collision_step",   32'(step),   32'h0);
    cyc(15);
    btn_n = 1'b1;
    cyc(10);
    press(1'b1, 1'b0, 8, 1'b1);            // -> 0001

    // Randomized presses.
    for (int i = 0; i < 40; i++)
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(8, 30), 1'b1);

    cyc(20);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
